sharpen_row_feeder: RTL
=======================

# sharpen_row_feeder

Streaming producer of 3-row operand triplets for the sharpen datapath. It accepts a raster-order stream of 32-bit pixel words (4 × 8-bit pixels, MSB byte leftmost) and buffers two image rows. For every word position it emits an {up, mid, down} triplet that maps directly onto the sharpen unit's up_row / rs1 / rs2 operands. Top and bottom image edges are handled by vertical reflection, matching the unit's horizontal edge reflection.

## Interface
- WORDS_PER_ROW, 16: 32-bit words per image row; must be ≥ 1.
- ROWS, 16: image rows per frame; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start pulse; ignored while busy.
- in_word  in  32  incoming pixel word, raster order.
- in_valid  in  1  in_word valid.
- in_ready  out  1  block accepts in_word this cycle.
- out_up  out  32  row r−1 word (reflected at edges).
- out_mid  out  32  row r word.
- out_down  out  32  row r+1 word (reflected at edges).
- out_valid  out  1  triplet valid.
- out_ready  in  1  consumer accepts triplet.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last triplet handshake.

## Operation
- Handshake on both sides is valid/ready. A transfer occurs when both are high on a rising edge.
- out_* data and out_valid are held stable while out_valid && !out_ready.
- Storage: per column c, two words prev[c] and cur[c]. Accepting a word at column c performs prev[c]←cur[c] and cur[c]←in_word.
- Counters: col runs 0..WORDS_PER_ROW−1 and wraps, incrementing row on wrap. row counts input rows 0..ROWS−1.
- States:
  - IDLE: in_ready=0. start → FILL0 with col=row=0, busy=1.
  - FILL0 (row 0 arriving): in_ready=1, no output. Last word of the row → FILL1.
  - FILL1 (row 1 arriving): in_ready = !out_valid || out_ready. Each accepted word loads the output register with up=in_word, mid=cur[c], down=in_word; this is the reflected row −1. Last word → STREAM if ROWS>2, else DRAIN.
  - STREAM (rows 2..ROWS−1 arriving): same in_ready rule. Each accepted word loads up=prev[c], mid=cur[c], down=in_word, i.e. emits row r−1. Last word of row ROWS−1 → DRAIN.
  - DRAIN: in_ready=0. Whenever the output slot is free, load up=prev[c], mid=cur[c], down=prev[c] (reflected row ROWS). This emits row ROWS−1 for c = 0..WORDS_PER_ROW−1. After the last drain triplet is handshaken → IDLE with done=1 for one cycle and busy=0.
- Total triplets per frame: ROWS × WORDS_PER_ROW, in raster order.
- Pixel data passes through unchanged; there is no arithmetic on pixels.

## Timing
- Reset values: in_ready=0, out_valid=0, out_up=out_mid=out_down=0, busy=0, done=0, state IDLE, counters 0. Buffer contents are don't-care.
- Latency: triplet appears (out_valid=1) on the cycle after the accepting input edge.
- Throughput: one word per cycle when out_ready is held high. An output handshake and a new input accept can occur in the same cycle; out_valid then stays 1 with the new data.
- start during busy: no effect. start and rst_n low together: reset wins.
- Reset mid-frame: everything returns immediately to reset values. The partial frame is discarded and no done pulse is produced.
- in_valid while in IDLE or DRAIN: the word is not accepted and the producer must hold it.

## Configuration
- SHARPEN_FEEDER_ZERO_PAD_EN defined: out-of-image rows are emitted as 32'h0.
  - Row 0: up=0.
  - Row ROWS−1: down=0.
- Undefined (default): out-of-image rows are reflected as described above.

## Structure
- Package sharpen_pkg holds:
  - PIX_W=8, WORD_W=32, PIX_PER_WORD=4.
  - State enum {IDLE, FILL0, FILL1, STREAM, DRAIN}.
- Sub-module sharpen_line_buf: 2 × WORDS_PER_ROW word storage.
  - Column-indexed read of prev/cur.
  - Write port performs the shift-on-write.

## Test plan
- WORDS_PER_ROW=2, ROWS=3, words = 32'h0R0C0R0C pattern (row R, col C), out_ready=1:
  - Row 0 triplets are up=row1, mid=row0, down=row1.
  - Row 1 triplets are up=row0, mid=row1, down=row2.
  - Row 2 triplets are up=row1, mid=row2, down=row1.
  - Six triplets total, then done pulses once.
- ROWS=2 minimum frame: FILL1 goes straight to DRAIN. Four triplets, last one up=down=row0.
- out_ready toggled 1010… with in_valid=1: no triplet is lost or duplicated, data is held stable while stalled, and in_ready=0 whenever out_valid && !out_ready.
- start pulsed mid-frame: ignored, and the frame completes with the correct count.
- rst_n asserted during STREAM: outputs return to 0 immediately, no done pulse, and a fresh frame afterwards is correct.
- SHARPEN_FEEDER_ZERO_PAD_EN build, same stimulus as the first case: row 0 up=32'h0 and row 2 down=32'h0.

Source files
------------

// File: rtl/sharpen_pkg.sv
// Shared constants, FSM state type and sizing helper for the sharpen row feeder.
package sharpen_pkg;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        FILL0,
        FILL1,
        STREAM,
        DRAIN
    } feeder_state_t;

    // Counter width for a range of n values; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sharpen_line_buf.sv
// Two-row word store: per column, a write shifts cur into prev and loads the new word into cur.
module sharpen_line_buf
    import sharpen_pkg::*;
#(
    parameter int WORDS_PER_ROW = 16,
    parameter int COL_W         = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [COL_W-1:0]  col,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] prev_word,
    output logic [WORD_W-1:0] cur_word
);

    logic [WORD_W-1:0] prev_mem [WORDS_PER_ROW];
    logic [WORD_W-1:0] cur_mem  [WORDS_PER_ROW];

    // NOTE: storage has no reset; contents are always written before they are read in a frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            prev_mem[col] <= cur_mem[col];
            cur_mem[col]  <= wr_data;
        end
    end

    // Reads see pre-write contents, which is what the same-column triplet needs.
    assign prev_word = prev_mem[col];
    assign cur_word  = cur_mem[col];

endmodule

// File: rtl/sharpen_row_feeder.sv
// Streams {up, mid, down} word triplets from a raster pixel stream, reflecting at top/bottom edges.
// Define SHARPEN_FEEDER_ZERO_PAD_EN to emit out-of-image rows as zero instead of reflecting.
module sharpen_row_feeder
    import sharpen_pkg::*;
#(
    parameter int WORDS_PER_ROW = 16,
    parameter int ROWS          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_up,
    output logic [WORD_W-1:0] out_mid,
    output logic [WORD_W-1:0] out_down,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = idx_w(WORDS_PER_ROW);
    localparam int ROW_W = idx_w(ROWS);

`ifdef SHARPEN_FEEDER_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    feeder_state_t     state, state_nxt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              drain_last;
    logic [WORD_W-1:0] prev_word, cur_word;
    logic [WORD_W-1:0] up_nxt, mid_nxt, down_nxt;
    logic              load, advance, done_nxt;
    logic              accept, slot_free, last_col, last_row;

    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign last_col  = (col == COL_W'(WORDS_PER_ROW - 1));
    assign last_row  = (row == ROW_W'(ROWS - 1));
    assign busy      = (state != IDLE);

    sharpen_line_buf #(
        .WORDS_PER_ROW (WORDS_PER_ROW),
        .COL_W         (COL_W)
    ) u_line_buf (
        .clk       (clk),
        .wr_en     (accept),
        .col       (col),
        .wr_data   (in_word),
        .prev_word (prev_word),
        .cur_word  (cur_word)
    );

    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            FILL0:         in_ready = 1'b1;
            FILL1, STREAM: in_ready = slot_free;
            default:       in_ready = 1'b0;
        endcase
    end

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        done_nxt  = 1'b0;
        up_nxt    = prev_word;
        mid_nxt   = cur_word;
        down_nxt  = in_word;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = FILL0;
            end
            FILL0: begin
                if (accept) begin
                    advance = 1'b1;
                    if (last_col) state_nxt = FILL1;
                end
            end
            FILL1: begin
                // Row 0 output: row -1 is the reflection of row 1, which is arriving now.
                up_nxt = ZERO_PAD ? '0 : in_word;
                if (accept) begin
                    advance = 1'b1;
                    load    = 1'b1;
                    if (last_col) state_nxt = (ROWS > 2) ? STREAM : DRAIN;
                end
            end
            STREAM: begin
                if (accept) begin
                    advance = 1'b1;
                    load    = 1'b1;
                    if (last_col && last_row) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                down_nxt = ZERO_PAD ? '0 : prev_word;
                if (!drain_last && slot_free) begin
                    advance = 1'b1;
                    load    = 1'b1;
                end
                if (drain_last && out_valid && out_ready) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            drain_last <= 1'b0;
            out_up     <= '0;
            out_mid    <= '0;
            out_down   <= '0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= done_nxt;
            if (load) begin
                out_up    <= up_nxt;
                out_mid   <= mid_nxt;
                out_down  <= down_nxt;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == IDLE && start) begin
                col        <= '0;
                row        <= '0;
                drain_last <= 1'b0;
            end else if (advance) begin
                if (last_col) begin
                    col <= '0;
                    if (state == DRAIN)          drain_last <= 1'b1;
                    else if (state_nxt != DRAIN) row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule
